insn_buffer: RTL and testbench
==============================

Name: insn_buffer

Overview:
- Halfword-granular instruction FIFO between the fetch stage and the decode stage.
- Fetch pushes one 32-bit fetch word per cycle, split into up to two 16-bit entries tagged with pc and fault. Decode pops up to two entries per cycle and sees the two oldest entries combinationally.
- A pipeline flush empties the buffer in one cycle.

Parameters:
- ENTRY_COUNT, 8, number of 16-bit entries; power of two, at least 4.
- PTR_WIDTH, $clog2(ENTRY_COUNT), read/write pointer width.
- COUNT_WIDTH, PTR_WIDTH+1, occupancy count width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- flush  in  1  pipeline flush from the pipeline controller
- write_valid  in  1  fetch presents a word this cycle
- write_pc  in  32  fetch word address; bit 0 always 0
- write_insn  in  32  fetch word data
- write_fault  in  1  instruction page fault on this fetch
- write_ready  out  1  buffer can accept a word: free entries >= 2
- readable_entry_count  out  COUNT_WIDTH  current occupancy
- read_entry_low_pc / _insn / _fault  out  32/16/1  oldest entry
- read_entry_high_pc / _insn / _fault  out  32/16/1  second-oldest entry
- read_low  in  1  pop one entry
- read_high  in  1  pop a second entry; legal only with read_low

Behaviour:
- Storage: ENTRY_COUNT entries of {pc[31:0], insn[15:0], fault}. Head and tail pointers wrap modulo ENTRY_COUNT. Count is kept in a separate register.
- Reset, sampled on rst_n low at the clock edge: head=0, tail=0, count=0. Entry contents are don't-care. All read_entry_* outputs are 0 while count=0.
- write_ready = (ENTRY_COUNT - count) >= 2, combinational from count only. It does not depend on same-cycle reads.
- Push happens when write_valid && write_ready && !flush:
  - write_pc[1]=0: push two entries, {write_pc, write_insn[15:0], write_fault} then {write_pc+2, write_insn[31:16], write_fault}.
  - write_pc[1]=1: push one entry only, {write_pc, write_insn[31:16], write_fault}.
- write_valid while !write_ready: no push. Fetch must hold the word.
- Pop count = read_low + (read_low && read_high), clamped to count:
  - read_low with count=0 pops nothing.
  - read_high with count<2 pops only the low entry.
  - read_high without read_low is ignored; an assertion flags it.
- Read outputs are combinational from entry[head] and entry[head+1 mod ENTRY_COUNT]. Each output is zeroed when its entry index is >= count.
- Latency: an entry written at edge N is visible at read_entry_low from cycle N+1. There is no bypass.
- Simultaneous push and pop in one cycle: count_next = count + pushed - popped. Valid at full occupancy minus 2 with 2 pushed and 2 popped.
- flush has priority over all else: head=tail=0, count=0 next cycle, and that cycle's push and pop are discarded.
- rst_n low mid-operation behaves identically to flush.
- Stall is handled by the consumer deasserting read_low/read_high. Contents hold.
- Assertions:
  - count <= ENTRY_COUNT.
  - write_pc[0]=0 when write_valid.
  - No push when !write_ready.

Decomposition:
- Shared package (ProcessorTypes):
  - InsnBufferEntry struct {pc, insn[15:0], fault}.
  - INSN_BUFFER_ENTRY_COUNT constant.
  - These are shared with the decode stage through the InsnBufferIF modport pair.
- One natural sub-module, insn_buffer_ram: ENTRY_COUNT x entry register file with two write ports (tail, tail+1) and two async read ports (head, head+1).
- Pointer, count and control logic stay in insn_buffer.

Test Plan:
- Reset, then hold rst_n=0 for 2 cycles -> count=0, write_ready=1, all read_entry_* = 0.
- Aligned write pc=0x1000, insn=0xAAAA5555, then no write; next cycle -> count=2, low={0x1000,0x5555,0}, high={0x1002,0xAAAA,0}; read_low+read_high -> count=0.
- Misaligned write pc=0x2002, insn=0x12345678 -> count=1, low={0x2002,0x1234}, high all 0; read_low+read_high -> pops 1, count=0.
- Fill with 4 aligned writes, no reads (ENTRY_COUNT=8) -> count=8, write_ready=0; 5th write_valid is not accepted; one read_low+read_high -> count=6, write_ready=1.
- Wrap plus simultaneous: steady stream of aligned writes with 2-entry reads for 20 cycles -> count constant at 2, pcs strictly sequential with stride 2 across pointer wrap, no drop or duplicate.
- Flush with write_valid=1 and read_low=1 at count=6 -> next cycle count=0, no push; fault=1 write afterwards -> both entries read back with fault=1.

Source files
------------

// File: rtl/insn_buffer_pkg.sv
// Types shared between the instruction buffer and the decode stage.
package insn_buffer_pkg;

    localparam int INSN_BUFFER_ENTRY_COUNT = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [15:0] insn;
        logic        fault;
    } insn_buffer_entry_t;

    function automatic insn_buffer_entry_t make_entry(input logic [31:0] pc,
                                                      input logic [15:0] insn,
                                                      input logic        fault);
        insn_buffer_entry_t e;
        e.pc    = pc;
        e.insn  = insn;
        e.fault = fault;
        return e;
    endfunction

endpackage

// File: rtl/insn_buffer_if.sv
// Fetch-side push and decode-side pop signals of the instruction buffer.
interface insn_buffer_if import insn_buffer_pkg::*; #(
    parameter int ENTRY_COUNT = INSN_BUFFER_ENTRY_COUNT
);
    localparam int COUNT_WIDTH = $clog2(ENTRY_COUNT) + 1;

    logic                   write_valid;
    logic [31:0]            write_pc;
    logic [31:0]            write_insn;
    logic                   write_fault;
    logic                   write_ready;
    logic [COUNT_WIDTH-1:0] readable_entry_count;
    logic [31:0]            read_entry_low_pc;
    logic [15:0]            read_entry_low_insn;
    logic                   read_entry_low_fault;
    logic [31:0]            read_entry_high_pc;
    logic [15:0]            read_entry_high_insn;
    logic                   read_entry_high_fault;
    logic                   read_low;
    logic                   read_high;

    // Fetch and decode together form the master side; the buffer is the slave.
    modport master (
        output write_valid, write_pc, write_insn, write_fault, read_low, read_high,
        input  write_ready, readable_entry_count,
               read_entry_low_pc, read_entry_low_insn, read_entry_low_fault,
               read_entry_high_pc, read_entry_high_insn, read_entry_high_fault
    );

    modport slave (
        input  write_valid, write_pc, write_insn, write_fault, read_low, read_high,
        output write_ready, readable_entry_count,
               read_entry_low_pc, read_entry_low_insn, read_entry_low_fault,
               read_entry_high_pc, read_entry_high_insn, read_entry_high_fault
    );

endinterface

// File: rtl/insn_buffer_ram.sv
// Entry register file: two write ports, two asynchronous read ports.
module insn_buffer_ram import insn_buffer_pkg::*; #(
    parameter  int ENTRY_COUNT = INSN_BUFFER_ENTRY_COUNT,
    localparam int PTR_WIDTH   = $clog2(ENTRY_COUNT)
) (
    input  logic                 clk,
    input  logic                 we0,
    input  logic [PTR_WIDTH-1:0] waddr0,
    input  insn_buffer_entry_t   wdata0,
    input  logic                 we1,
    input  logic [PTR_WIDTH-1:0] waddr1,
    input  insn_buffer_entry_t   wdata1,
    input  logic [PTR_WIDTH-1:0] raddr0,
    input  logic [PTR_WIDTH-1:0] raddr1,
    output insn_buffer_entry_t   rdata0,
    output insn_buffer_entry_t   rdata1
);

    insn_buffer_entry_t mem_q [ENTRY_COUNT];
    insn_buffer_entry_t mem_d [ENTRY_COUNT];

    // waddr0 and waddr1 are always distinct (tail, tail+1), so port order is irrelevant.
    always_comb begin
        mem_d = mem_q;
        if (we0) mem_d[waddr0] = wdata0;
        if (we1) mem_d[waddr1] = wdata1;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rdata0 = mem_q[raddr0];
    assign rdata1 = mem_q[raddr1];

endmodule

// File: rtl/insn_buffer.sv
// Halfword-granular instruction FIFO between fetch and decode; pointer, count and control.
module insn_buffer import insn_buffer_pkg::*; #(
    parameter  int ENTRY_COUNT = INSN_BUFFER_ENTRY_COUNT,
    localparam int PTR_WIDTH   = $clog2(ENTRY_COUNT),
    localparam int COUNT_WIDTH = PTR_WIDTH + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    insn_buffer_if.slave  bus
);

    logic [PTR_WIDTH-1:0]   head_q, head_d;
    logic [PTR_WIDTH-1:0]   tail_q, tail_d;
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    logic               write_ready;
    logic               push;
    logic               push_two;
    logic [1:0]         push_n;
    logic [1:0]         pop_req;
    logic [1:0]         pop_n;
    insn_buffer_entry_t wdata0, wdata1;
    insn_buffer_entry_t rdata0, rdata1;

    assign write_ready = count_q <= COUNT_WIDTH'(ENTRY_COUNT - 2);

    always_comb begin
        push     = bus.write_valid && write_ready && !flush;
        push_two = push && !bus.write_pc[1];
        push_n   = {1'b0, push} + {1'b0, push_two};
        pop_req  = {1'b0, bus.read_low} + {1'b0, bus.read_low && bus.read_high};
        // Over-request only happens with count < 2, so the low bits of count are exact.
        pop_n    = (COUNT_WIDTH'(pop_req) > count_q) ? count_q[1:0] : pop_req;

        wdata0 = make_entry(bus.write_pc,
                            bus.write_pc[1] ? bus.write_insn[31:16] : bus.write_insn[15:0],
                            bus.write_fault);
        wdata1 = make_entry(bus.write_pc + 32'd2, bus.write_insn[31:16], bus.write_fault);

        head_d  = head_q + PTR_WIDTH'(pop_n);
        tail_d  = tail_q + PTR_WIDTH'(push_n);
        count_d = count_q + COUNT_WIDTH'(push_n) - COUNT_WIDTH'(pop_n);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    insn_buffer_ram #(.ENTRY_COUNT(ENTRY_COUNT)) u_ram (
        .clk    (clk),
        .we0    (push),
        .waddr0 (tail_q),
        .wdata0 (wdata0),
        .we1    (push_two),
        .waddr1 (tail_q + PTR_WIDTH'(1)),
        .wdata1 (wdata1),
        .raddr0 (head_q),
        .raddr1 (head_q + PTR_WIDTH'(1)),
        .rdata0 (rdata0),
        .rdata1 (rdata1)
    );

    assign bus.write_ready          = write_ready;
    assign bus.readable_entry_count = count_q;

    // Stale storage is never exposed: each slot reads zero unless occupied.
    always_comb begin
        bus.read_entry_low_pc     = '0;
        bus.read_entry_low_insn   = '0;
        bus.read_entry_low_fault  = 1'b0;
        bus.read_entry_high_pc    = '0;
        bus.read_entry_high_insn  = '0;
        bus.read_entry_high_fault = 1'b0;
        if (count_q != '0) begin
            bus.read_entry_low_pc    = rdata0.pc;
            bus.read_entry_low_insn  = rdata0.insn;
            bus.read_entry_low_fault = rdata0.fault;
        end
        if (count_q >= COUNT_WIDTH'(2)) begin
            bus.read_entry_high_pc    = rdata1.pc;
            bus.read_entry_high_insn  = rdata1.insn;
            bus.read_entry_high_fault = rdata1.fault;
        end
    end

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n)
        count_q <= COUNT_WIDTH'(ENTRY_COUNT));
    a_pc_aligned: assert property (@(posedge clk) disable iff (!rst_n)
        bus.write_valid |-> !bus.write_pc[0]);
    a_push_ready: assert property (@(posedge clk) disable iff (!rst_n)
        push |-> write_ready);
    a_high_needs_low: assert property (@(posedge clk) disable iff (!rst_n)
        bus.read_high |-> bus.read_low);

endmodule

// File: tb/tb_insn_buffer.sv
// Directed bench for insn_buffer with a queue scoreboard of expected entries.
module tb_insn_buffer;
    import insn_buffer_pkg::*;

    localparam int N = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;

    always #5 clk = ~clk;

    insn_buffer_if #(.ENTRY_COUNT(N)) bus ();

    insn_buffer #(.ENTRY_COUNT(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;
    insn_buffer_entry_t sb[$];

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] low_obs();
        return 64'({bus.read_entry_low_pc, bus.read_entry_low_insn, bus.read_entry_low_fault});
    endfunction

    function automatic logic [63:0] high_obs();
        return 64'({bus.read_entry_high_pc, bus.read_entry_high_insn, bus.read_entry_high_fault});
    endfunction

    function automatic logic [63:0] ent(input logic [31:0] pc, input logic [15:0] insn,
                                        input logic fault);
        return 64'({pc, insn, fault});
    endfunction

    task automatic check_state();
        insn_buffer_entry_t e0, e1;
        e0 = (sb.size() > 0) ? sb[0] : '0;
        e1 = (sb.size() > 1) ? sb[1] : '0;
        chk("sb_count", 64'(bus.readable_entry_count), 64'(sb.size()));
        chk("sb_ready", 64'(bus.write_ready), 64'((N - sb.size()) >= 2));
        chk("sb_low", low_obs(), 64'(e0));
        chk("sb_high", high_obs(), 64'(e1));
    endtask

    // One clock: check current outputs, drive inputs, advance the model, step past the edge.
    task automatic cycle(input bit wv, input logic [31:0] pc, input logic [31:0] insn,
                         input bit f, input bit rl, input bit rh, input bit fl);
        int pops;
        bit rdy;
        if (chk_en) check_state();
        bus.write_valid = wv;
        bus.write_pc    = pc;
        bus.write_insn  = insn;
        bus.write_fault = f;
        bus.read_low    = rl;
        bus.read_high   = rh;
        flush           = fl;
        if (!rst_n || fl) begin
            sb.delete();
        end else begin
            pops = rl ? (rh ? 2 : 1) : 0;
            if (pops > sb.size()) pops = sb.size();
            rdy = (N - sb.size()) >= 2;
            repeat (pops) void'(sb.pop_front());
            if (wv && rdy) begin
                if (pc[1]) begin
                    sb.push_back('{pc: pc, insn: insn[31:16], fault: f});
                end else begin
                    sb.push_back('{pc: pc, insn: insn[15:0], fault: f});
                    sb.push_back('{pc: pc + 32'd2, insn: insn[31:16], fault: f});
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop2();
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        idle();
        chk_en = 1'b1;
        idle();
        chk("rst_count", 64'(bus.readable_entry_count), 64'd0);
        chk("rst_ready", 64'(bus.write_ready), 64'd1);
        chk("rst_low", low_obs(), 64'd0);
        chk("rst_high", high_obs(), 64'd0);
        rst_n = 1'b1;

        // Aligned word: two entries, low half first.
        cycle(1'b1, 32'h1000, 32'hAAAA5555, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("al_count", 64'(bus.readable_entry_count), 64'd2);
        chk("al_low", low_obs(), ent(32'h1000, 16'h5555, 1'b0));
        chk("al_high", high_obs(), ent(32'h1002, 16'hAAAA, 1'b0));
        pop2();
        chk("al_drain", 64'(bus.readable_entry_count), 64'd0);

        // Misaligned word: only the upper half is pushed.
        cycle(1'b1, 32'h2002, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("mis_count", 64'(bus.readable_entry_count), 64'd1);
        chk("mis_low", low_obs(), ent(32'h2002, 16'h1234, 1'b0));
        chk("mis_high", high_obs(), 64'd0);
        pop2();
        chk("mis_drain", 64'(bus.readable_entry_count), 64'd0);

        // Pop request on an empty buffer.
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("empty_pop", 64'(bus.readable_entry_count), 64'd0);

        // Fill to capacity, then a held write must wait.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 32'h3000 + 32'(4 * i), {16'(2 * i + 1), 16'(2 * i)},
                  1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_count", 64'(bus.readable_entry_count), 64'd8);
        chk("full_ready", 64'(bus.write_ready), 64'd0);
        cycle(1'b1, 32'h3010, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("full_hold", 64'(bus.readable_entry_count), 64'd8);
        cycle(1'b1, 32'h3010, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("full_pop_count", 64'(bus.readable_entry_count), 64'd6);
        chk("full_pop_ready", 64'(bus.write_ready), 64'd1);
        for (int i = 0; i < 3; i++) pop2();
        chk("full_drain", 64'(bus.readable_entry_count), 64'd0);

        // Steady stream across pointer wrap: occupancy stays at two.
        cycle(1'b1, 32'h4000, 32'h00010000, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 32'h4000 + 32'(4 * i), {16'(2 * i + 1), 16'(2 * i)},
                  1'b0, 1'b1, 1'b1, 1'b0);
            chk("stream_count", 64'(bus.readable_entry_count), 64'd2);
        end
        chk("stream_low", low_obs(), ent(32'h4050, 16'd40, 1'b0));
        pop2();
        chk("stream_drain", 64'(bus.readable_entry_count), 64'd0);

        // Flush discards the same-cycle push and pop.
        for (int i = 0; i < 3; i++)
            cycle(1'b1, 32'h5000 + 32'(4 * i), 32'hC0DE0000 | 32'(i),
                  1'b0, 1'b0, 1'b0, 1'b0);
        chk("pre_flush", 64'(bus.readable_entry_count), 64'd6);
        cycle(1'b1, 32'h6000, 32'h11112222, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("flush_count", 64'(bus.readable_entry_count), 64'd0);
        chk("flush_low", low_obs(), 64'd0);
        idle();

        // Faulting fetch tags both halves.
        cycle(1'b1, 32'h7000, 32'hBEEFCAFE, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("fault_low", low_obs(), ent(32'h7000, 16'hCAFE, 1'b1));
        chk("fault_high", high_obs(), ent(32'h7002, 16'hBEEF, 1'b1));
        pop2();

        // Reset mid-operation clears like flush.
        cycle(1'b1, 32'h8000, 32'h33334444, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        cycle(1'b1, 32'h8004, 32'h55556666, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("midrst_count", 64'(bus.readable_entry_count), 64'd0);
        rst_n = 1'b1;
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
